aer_spike_binner: RTL and testbench

- Sits directly downstream of the AER input pipeline; consumes its decoded (channel_Id, timestamp, timestamp_valid) event stream.
- Counts spikes per channel (16 channels) inside fixed timestamp windows of 2^WIN_SHIFT ticks.
- When a window closes, streams one count word per channel to the neural core over a valid/ready handshake.
- Ping-pong count banks let accumulation continue while the previous window drains.

---
 rtl/aer_spike_binner_if.sv | 38 +++
 rtl/aer_spike_binner.sv | 140 ++++++++++++++
 tb/tb_aer_spike_binner.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aer_spike_binner_if.sv
// Count-word stream from the spike binner to the neural core.
//   bin_valid   : word valid (binner -> core)
//   bin_ready   : core accepts the word when bin_valid && bin_ready
//   bin_channel : channel of the word, 0..15 ascending within a window
//   bin_count   : spike count of bin_channel in the emitted window
//   bin_window  : window index of the emitted window
//   bin_last    : high on the channel-15 word
interface aer_spike_binner_if #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned WIN_W = 10
) ();

   logic             bin_valid;
   logic             bin_ready;
   logic [3:0]       bin_channel;
   logic [CNT_W-1:0] bin_count;
   logic [WIN_W-1:0] bin_window;
   logic             bin_last;

   modport master (
      output bin_valid,
      output bin_channel,
      output bin_count,
      output bin_window,
      output bin_last,
      input  bin_ready
   );

   modport slave (
      input  bin_valid,
      input  bin_channel,
      input  bin_count,
      input  bin_window,
      input  bin_last,
      output bin_ready
   );

endinterface

// File: rtl/aer_spike_binner.sv
// Per-channel spike binner: counts AER spikes for 16 channels inside fixed
// timestamp windows of 2^WIN_SHIFT ticks and, when a window closes, streams
// one saturating count word per channel over a valid/ready handshake.
// Two count banks ping-pong so accumulation continues while a closed window
// drains.
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   channel_Id      : channel of the incoming spike
//   timestamp       : 20-bit timestamp of the incoming spike
//   timestamp_valid : spike qualifier, at most one spike per cycle
//   flush_req       : single-cycle pulse force-closing the open window
//   bin             : count-word stream (master side)
//   overrun         : one-cycle pulse when a closed window is dropped
//   busy            : flush engine is draining a bank
module aer_spike_binner #(
   parameter int unsigned WIN_SHIFT = 10,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3:0]                channel_Id,
   input  logic [19:0]               timestamp,
   input  logic                      timestamp_valid,
   input  logic                      flush_req,
   aer_spike_binner_if.master        bin,
   output logic                      overrun,
   output logic                      busy
);

   localparam int unsigned TS_W  = 20;
   localparam int unsigned WIN_W = TS_W - WIN_SHIFT;
   localparam int unsigned NCH   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic { NO_WIN, OPEN }     acc_state_t;
   typedef enum logic { FL_IDLE, FL_SEND } fl_state_t;

   acc_state_t       acc_state;
   fl_state_t        fl_state;
   logic [CNT_W-1:0] bank [2][NCH];
   logic             act_bank;
   logic             fl_bank;
   logic [WIN_W-1:0] cur_win;

   logic [WIN_W-1:0] ev_win_c;
   logic             close_c;
   logic             handover_c;
   logic             accept_c;
   logic             spike_bank_c;

   // Event decode: window of the incoming spike, close/handover/accept strobes
   always_comb begin
      ev_win_c     = timestamp[TS_W-1:WIN_SHIFT];
      close_c      = (acc_state == OPEN) &&
                     (flush_req || (timestamp_valid && (ev_win_c != cur_win)));
      handover_c   = close_c && (fl_state == FL_IDLE);
      accept_c     = (fl_state == FL_SEND) && bin.bin_valid && bin.bin_ready;
      // A handover toggles the active bank, so the closing spike lands in the other one
      spike_bank_c = handover_c ? ~act_bank : act_bank;
   end

   // Accumulator FSM, flush engine and count banks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned c = 0; c < NCH; c++) begin
               bank[1'(b)][4'(c)] <= '0;
            end
         end
         acc_state       <= NO_WIN;
         fl_state        <= FL_IDLE;
         act_bank        <= 1'b0;
         fl_bank         <= 1'b0;
         cur_win         <= '0;
         bin.bin_valid   <= 1'b0;
         bin.bin_channel <= '0;
         bin.bin_count   <= '0;
         bin.bin_window  <= '0;
         bin.bin_last    <= 1'b0;
         overrun         <= 1'b0;
         busy            <= 1'b0;
      end else begin
         overrun <= 1'b0;

         // Drain: each accepted word clears its bank entry and advances the channel
         if (accept_c) begin
            bank[fl_bank][bin.bin_channel] <= '0;
            if (bin.bin_last) begin
               fl_state        <= FL_IDLE;
               bin.bin_valid   <= 1'b0;
               bin.bin_channel <= '0;
               bin.bin_count   <= '0;
               bin.bin_window  <= '0;
               bin.bin_last    <= 1'b0;
               busy            <= 1'b0;
            end else begin
               bin.bin_channel <= bin.bin_channel + 4'd1;
               bin.bin_count   <= bank[fl_bank][bin.bin_channel + 4'd1];
               bin.bin_last    <= (bin.bin_channel == 4'd14);
            end
         end

         // Window close: hand the bank to an idle engine, otherwise drop it.
         // The engine still counts as busy in the cycle of its last accept.
         if (close_c) begin
            if (handover_c) begin
               fl_state        <= FL_SEND;
               fl_bank         <= act_bank;
               act_bank        <= ~act_bank;
               bin.bin_valid   <= 1'b1;
               bin.bin_channel <= 4'd0;
               bin.bin_count   <= bank[act_bank][4'd0];
               bin.bin_window  <= cur_win;
               bin.bin_last    <= 1'b0;
               busy            <= 1'b1;
            end else begin
               overrun <= 1'b1;
               for (int unsigned c = 0; c < NCH; c++) begin
                  bank[act_bank][4'(c)] <= '0;
               end
            end
         end

         // Accumulate: a spike that opens a window starts its channel at 1
         // (overriding the drop-clear above), otherwise saturating increment
         if (timestamp_valid) begin
            acc_state <= OPEN;
            if ((acc_state == NO_WIN) || close_c) begin
               cur_win                        <= ev_win_c;
               bank[spike_bank_c][channel_Id] <= CNT_W'(1);
            end else if (bank[act_bank][channel_Id] != CNT_MAX) begin
               bank[act_bank][channel_Id] <= bank[act_bank][channel_Id] + CNT_W'(1);
            end
         end else if (close_c) begin
            acc_state <= NO_WIN;
         end
      end
   end

endmodule

// File: tb/tb_aer_spike_binner.sv
// Self-checking bench for aer_spike_binner: directed scenarios followed by a
// randomized phase, checked against a window-level reference model with an
// expected-word scoreboard popped by an independent monitor.
module tb_aer_spike_binner;

   localparam int unsigned WIN_SHIFT = 10;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned WIN_W     = 20 - WIN_SHIFT;
   localparam int          CNT_MAX   = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [3:0]       ch;
      logic [CNT_W-1:0] cnt;
      logic [WIN_W-1:0] win;
      logic             last;
   } word_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  channel_Id = '0;
   logic [19:0] timestamp = '0;
   logic        timestamp_valid = 1'b0;
   logic        flush_req = 1'b0;
   logic        overrun;
   logic        busy;

   aer_spike_binner_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bif ();

   aer_spike_binner #(.WIN_SHIFT(WIN_SHIFT), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .channel_Id      (channel_Id),
      .timestamp       (timestamp),
      .timestamp_valid (timestamp_valid),
      .flush_req       (flush_req),
      .bin             (bif.master),
      .overrun         (overrun),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int rdy_mode = 0;   // 0 high, 1 low, 2 toggle, 3 random

   word_t sb[$];

   // Reference model: spike counts of the open window and drain occupancy
   int m_cnt [16];
   bit m_open  = 1'b0;
   int m_win   = 0;
   bit m_valid = 1'b0;
   int m_left  = 0;
   bit m_ovr   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 16; c++) m_cnt[c] = 0;
      m_open  = 1'b0;
      m_win   = 0;
      m_valid = 1'b0;
      m_left  = 0;
      m_ovr   = 1'b0;
      sb.delete();
   endtask

   // Model process: checks handshake/status outputs, then advances one cycle
   always @(negedge clk) begin
      if (rst) begin
         model_reset();
         chk("reset_outputs", 32'({bif.bin_valid, busy, overrun, bif.bin_last,
                                   bif.bin_channel, bif.bin_count, bif.bin_window}), 32'd0);
      end else begin
         bit    acc, close, hand;
         int    w;
         word_t wd;
         chk("bin_valid", 32'(bif.bin_valid), 32'(m_valid));
         chk("busy",      32'(busy),          32'(m_valid));
         chk("overrun",   32'(overrun),       32'(m_ovr));

         acc   = m_valid && bif.bin_ready;
         w     = int'(timestamp) >> WIN_SHIFT;
         close = m_open && (flush_req || (timestamp_valid && (w != m_win)));
         hand  = 1'b0;
         m_ovr = 1'b0;
         if (close) begin
            if (m_valid) m_ovr = 1'b1;
            else begin
               hand = 1'b1;
               for (int c = 0; c < 16; c++) begin
                  wd.ch   = 4'(c);
                  wd.cnt  = CNT_W'(m_cnt[c]);
                  wd.win  = WIN_W'(m_win);
                  wd.last = (c == 15);
                  sb.push_back(wd);
               end
            end
            for (int c = 0; c < 16; c++) m_cnt[c] = 0;
            m_open = 1'b0;
         end
         if (timestamp_valid) begin
            if (!m_open) begin
               m_open = 1'b1;
               m_win  = w;
            end
            if (m_cnt[channel_Id] < CNT_MAX) m_cnt[channel_Id]++;
         end
         if (acc) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b0;
         end
         if (hand) begin
            m_valid = 1'b1;
            m_left  = 16;
         end
      end
   end

   // Monitor: presented word must match the scoreboard head; pop on accept
   always @(negedge clk) begin
      if (!rst && bif.bin_valid) begin
         if (sb.size() == 0) begin
            chk("bin_unexpected", 32'({bif.bin_channel, bif.bin_count, bif.bin_window, bif.bin_last}),
                32'hFFFF_FFFF);
         end else begin
            chk("bin_word", 32'({bif.bin_channel, bif.bin_count, bif.bin_window, bif.bin_last}),
                32'(sb[0]));
            if (bif.bin_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic step(input logic tv, input logic [3:0] ch, input logic [19:0] ts, input logic fl);
      timestamp_valid = tv;
      channel_Id      = ch;
      timestamp       = ts;
      flush_req       = fl;
      case (rdy_mode)
         0:       bif.bin_ready = 1'b1;
         1:       bif.bin_ready = 1'b0;
         2:       bif.bin_ready = ~bif.bin_ready;
         default: bif.bin_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      #1;
      timestamp_valid = 1'b0;
      flush_req       = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 20'd0, 1'b0);
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((bif.bin_valid || busy) && (k < 400)) begin
         step(1'b0, 4'd0, 20'd0, 1'b0);
         k++;
      end
      if (k >= 400) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: got busy=%0b expected busy=0", busy);
      end
   endtask

   initial begin
      logic [19:0] rts;
      int          k;
      bif.bin_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Window 0 closed by a window-1 spike
      rdy_mode = 0;
      step(1'b1, 4'd3, 20'd5,    1'b0);
      step(1'b1, 4'd3, 20'd100,  1'b0);
      step(1'b1, 4'd7, 20'd1023, 1'b0);
      step(1'b1, 4'd0, 20'd1024, 1'b0);
      wait_drain();

      // Saturation in window 2, flush, then a flush in NO_WIN is ignored
      for (int i = 0; i < 300; i++) step(1'b1, 4'd9, 20'(2048 + i), 1'b0);
      step(1'b0, 4'd0, 20'd0, 1'b1);
      wait_drain();
      step(1'b0, 4'd0, 20'd0, 1'b1);
      idle(5);

      // Overrun: window 1 closes while window 0 is stalled
      rdy_mode = 1;
      step(1'b1, 4'd2, 20'd0,    1'b0);
      step(1'b1, 4'd4, 20'd1024, 1'b0);
      idle(3);
      step(1'b1, 4'd5, 20'd2048, 1'b0);
      idle(3);
      rdy_mode = 0;
      wait_drain();
      step(1'b0, 4'd0, 20'd0, 1'b1);
      wait_drain();

      // Drain with ready toggling every cycle
      rdy_mode = 2;
      step(1'b1, 4'd1,  20'd3000, 1'b0);
      step(1'b1, 4'd1,  20'd3001, 1'b0);
      step(1'b1, 4'd15, 20'd3002, 1'b0);
      step(1'b0, 4'd0,  20'd0,    1'b1);
      wait_drain();

      // Timestamp wrap closes window 0x3FF
      rdy_mode = 0;
      step(1'b1, 4'd6, 20'hFFC00, 1'b0);
      step(1'b1, 4'd2, 20'h00010, 1'b0);
      wait_drain();
      step(1'b0, 4'd0, 20'd0, 1'b1);
      wait_drain();

      // Reset in the middle of a drain
      step(1'b1, 4'd3, 20'd5000, 1'b0);
      step(1'b1, 4'd8, 20'd5001, 1'b0);
      step(1'b0, 4'd0, 20'd0,    1'b1);
      k = 0;
      while (!(bif.bin_valid && (bif.bin_channel == 4'd8)) && (k < 50)) begin
         step(1'b0, 4'd0, 20'd0, 1'b0);
         k++;
      end
      chk("reach_word8", 32'(bif.bin_channel), 32'd8);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset", 32'({bif.bin_valid, busy, overrun, bif.bin_last,
                              bif.bin_channel, bif.bin_count, bif.bin_window}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 4'd1, 20'd0, 1'b0);
      step(1'b0, 4'd0, 20'd0, 1'b1);
      wait_drain();

      // Randomized traffic across the 20-bit timestamp wrap
      rts = 20'hFC000;
      for (int i = 0; i < 3000; i++) begin
         if ((i % 200) == 0) rdy_mode = int'($urandom_range(0, 3));
         rts = rts + 20'($urandom_range(0, 40));
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rts,
              1'($urandom_range(0, 49) == 0));
      end
      rdy_mode = 0;
      wait_drain();
      step(1'b0, 4'd0, 20'd0, 1'b1);
      wait_drain();
      idle(3);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
